// File: rtl/spi_master_driver_pkg.sv
// spi_master_driver_pkg: shared state, frame-size and command encodings for the SPI master driver
package spi_master_driver_pkg;
  typedef enum logic [2:0] {M_IDLE, M_SHIFT, M_WAIT, M_CAPTURE, M_GAP} spi_master_state_e;
  localparam int FRAME_BITS = 11;
  localparam int RDATA_BITS = 8;
  localparam logic [2:0] WRITE_ADDR = 3'b000;
  localparam logic [2:0] WRITE_DATA = 3'b001;
  localparam logic [2:0] READ_ADDR  = 3'b110;
  localparam logic [2:0] READ_DATAA = 3'b111;
  function automatic logic cmd_legal(input logic [2:0] c);
    return c inside {WRITE_ADDR, WRITE_DATA, READ_ADDR, READ_DATAA};
  endfunction
endpackage

// File: rtl/spi_master_driver.sv
// spi_master_driver: serialises one command/byte request into an SS_n/MOSI frame and captures the MISO reply
module spi_master_driver
  import spi_master_driver_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MIN_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       cmd_err,
  output logic       busy
);
  localparam logic [4:0] SHIFT_LOAD = 5'(FRAME_BITS - 1);
  localparam logic [4:0] CAP_LOAD = 5'(RDATA_BITS - 1);
  localparam logic [4:0] WAIT_LOAD = 5'(READ_LATENCY - 1);
  localparam logic [4:0] GAP_LOAD = 5'(MIN_GAP - 1);
  spi_master_state_e state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [FRAME_BITS-1:0] sreg;
  logic [RDATA_BITS-2:0] rx;
  logic rd;
  logic accept;
  assign accept = req_valid && req_ready;
  assign req_ready = state == M_IDLE && !rst;
  assign busy = state != M_IDLE;
  assign SS_n = !(state inside {M_SHIFT, M_WAIT, M_CAPTURE});
  assign MOSI = state == M_SHIFT && sreg[FRAME_BITS-1];
  always_comb begin
    state_n = state;
    cnt_n = cnt - 5'd1;
    case (state)
      M_IDLE: if (accept && cmd_legal(req_cmd)) begin
        state_n = M_SHIFT;
        cnt_n = SHIFT_LOAD;
      end
      M_SHIFT: if (cnt == 5'd0) begin
        state_n = !rd ? M_GAP : READ_LATENCY == 0 ? M_CAPTURE : M_WAIT;
        cnt_n = !rd ? GAP_LOAD : READ_LATENCY == 0 ? CAP_LOAD : WAIT_LOAD;
      end
      M_WAIT: if (cnt == 5'd0) begin
        state_n = M_CAPTURE;
        cnt_n = CAP_LOAD;
      end
      M_CAPTURE: if (cnt == 5'd0) begin
        state_n = M_GAP;
        cnt_n = GAP_LOAD;
      end
      M_GAP: if (cnt == 5'd0) state_n = M_IDLE;
      default: state_n = M_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= M_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // Response byte is published on the last capture edge so rsp_valid lands in the first GAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      rx <= '0;
      rd <= 1'b0;
      rsp_data <= '0;
      rsp_valid <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      rsp_valid <= state == M_CAPTURE && cnt == 5'd0;
      cmd_err <= accept && !cmd_legal(req_cmd);
      if (accept) begin
        sreg <= {req_cmd, req_data};
        rd <= req_cmd == READ_DATAA;
      end else if (state == M_SHIFT) sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
      if (state == M_CAPTURE) begin
        rx <= {rx[RDATA_BITS-3:0], MISO};
        if (cnt == 5'd0) rsp_data <= {rx, MISO};
      end
    end
  end
endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: directed checks of frame timing, read capture, illegal commands and reset abort
module tb_spi_master_driver;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, SS_n, MOSI, MISO, rsp_valid, cmd_err, busy;
  logic [2:0] req_cmd;
  logic [7:0] req_data, rsp_data;
  int nvec = 0;
  int nerr = 0;
  logic [7:0] ram [256];
  logic [7:0] saddr = 8'h00;
  logic [10:0] sfr = '0;
  int sidx = 0;

  spi_master_driver #(.READ_LATENCY(2), .MIN_GAP(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave+RAM model: frame cycle k (1-based) is seen at the negedge inside it; reply bits start at cycle 14.
  initial begin
    MISO = 1'b1;
    forever begin
      @(negedge clk);
      if (SS_n) begin
        sidx = 0;
        MISO = 1'b1;
      end else begin
        sidx = sidx + 1;
        if (sidx <= 11) sfr = {sfr[9:0], MOSI};
        if (sidx == 11) begin
          if (sfr[10:8] == 3'b000 || sfr[10:8] == 3'b110) saddr = sfr[7:0];
          if (sfr[10:8] == 3'b001) ram[saddr] = sfr[7:0];
        end
        MISO = (sidx >= 14 && sidx <= 21) ? ram[saddr][21 - sidx] : 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] d);
    req_cmd = c;
    req_data = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", req_ready, 1'b1);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] f);
    for (int k = 0; k < 11; k++) begin
      check({tag, "_mosi"}, MOSI, f[10-k]);
      check({tag, "_ssn"}, SS_n, 1'b0);
      tick();
    end
  endtask

  initial begin
    int a1, a2, cyc, highs, seen;
    rst = 1'b1;
    req_valid = 1'b0;
    req_cmd = 3'b000;
    req_data = 8'h00;
    repeat (3) begin
      tick();
      check("rst_ssn", SS_n, 1'b1);
      check("rst_ready", req_ready, 1'b0);
      check("rst_mosi", MOSI, 1'b0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_ssn", SS_n, 1'b1);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_rspv", rsp_valid, 1'b0);
    check("post_rst_rspd", rsp_data, 8'h00);
    check("post_rst_err", cmd_err, 1'b0);

    send(3'b000, 8'hA5);
    check("wa_busy", busy, 1'b1);
    check("wa_ready", req_ready, 1'b0);
    check_frame("wa", 11'b000_1010_0101);
    check("wa_n12_ssn", SS_n, 1'b1);
    check("wa_n12_ready", req_ready, 1'b0);
    tick();
    check("wa_n13_ready", req_ready, 1'b1);
    check("wa_n13_busy", busy, 1'b0);

    ram[8'hA5] = 8'h3C;
    send(3'b111, 8'h00);
    for (int k = 1; k <= 21; k++) begin
      check("rd_ssn", SS_n, 1'b0);
      check("rd_rspv_early", rsp_valid, 1'b0);
      if (k >= 12) check("rd_mosi_idle", MOSI, 1'b0);
      tick();
    end
    check("rd_n22_rspv", rsp_valid, 1'b1);
    check("rd_n22_rspd", rsp_data, 8'h3C);
    check("rd_n22_ssn", SS_n, 1'b1);
    tick();
    check("rd_n23_rspv", rsp_valid, 1'b0);
    check("rd_n23_hold", rsp_data, 8'h3C);
    check("rd_n23_ready", req_ready, 1'b1);

    send(3'b010, 8'h55);
    check("ill_err", cmd_err, 1'b1);
    check("ill_ssn", SS_n, 1'b1);
    check("ill_ready", req_ready, 1'b1);
    check("ill_busy", busy, 1'b0);
    tick();
    check("ill_err_pulse", cmd_err, 1'b0);
    check("ill_ssn2", SS_n, 1'b1);

    send(3'b111, 8'h00);
    repeat (5) tick();
    check("abort_n6_ssn", SS_n, 1'b0);
    rst = 1'b1;
    tick();
    check("abort_ssn", SS_n, 1'b1);
    check("abort_mosi", MOSI, 1'b0);
    check("abort_rspv", rsp_valid, 1'b0);
    check("abort_err", cmd_err, 1'b0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rsp_valid || !SS_n) seen++;
    end
    check("abort_quiet", 8'(seen), 8'd0);
    send(3'b001, 8'hFF);
    check_frame("wd", 11'b001_1111_1111);
    check("wd_end_ssn", SS_n, 1'b1);
    wait_idle();

    req_cmd = 3'b000;
    req_data = 8'h10;
    req_valid = 1'b1;
    a1 = -1;
    a2 = -1;
    highs = 0;
    cyc = 0;
    while (a2 < 0 && cyc < 60) begin
      if (a1 >= 0 && SS_n) highs++;
      if (req_valid && req_ready) begin
        if (a1 < 0) begin
          a1 = cyc;
          tick();
          cyc++;
          req_cmd = 3'b001;
          req_data = 8'h20;
          continue;
        end
        a2 = cyc;
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    check("b2b_spacing", 8'(a2 - a1), 8'd13);
    check("b2b_gap_high", 8'(highs), 8'd2);
    wait_idle();
    send(3'b110, 8'h10);
    wait_idle();
    send(3'b111, 8'h00);
    seen = 0;
    while (!rsp_valid && seen < 40) begin
      tick();
      seen++;
    end
    check("e2e_rspv", rsp_valid, 1'b1);
    check("e2e_rspd", rsp_data, 8'h20);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
